// File: rtl/config_loader_pkg.sv
// Shared types and defaults for the configuration latch-bank loader.
package config_loader_pkg;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_NUM_WORDS = 18;
    localparam int DEF_IDX_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        STROBE,
        HOLD,
        CHK
    } state_t;

    // True when an idx_w-bit counter can address every bank (2^idx_w > num_words).
    function automatic bit idx_w_fits(input int idx_w, input int num_words);
        return idx_w >= $clog2(num_words + 1);
    endfunction

endpackage

// File: rtl/config_en_decoder.sv
// Index-to-one-hot latch-enable decoder, gated by a strobe; registered by the parent.
module config_en_decoder #(
    parameter int NUM_WORDS = 18,
    parameter int IDX_W     = 5
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 strobe,
    output logic [NUM_WORDS-1:0] en
);

    always_comb begin
        en = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            en[i] = strobe && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/config_loader.sv
// Streams config words onto a stable bus and pulses one latch enable per word
// (FETCH/SETUP/STROBE/HOLD). Optional trailing checksum word: CFG_LOADER_CHECKSUM_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WORD_W-1:0]    io_in_data,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
`ifdef CFG_LOADER_CHECKSUM_EN
    output logic                 io_cfg_err,
`endif
    output logic [IDX_W-1:0]     io_word_idx
);

    if (!idx_w_fits(IDX_W, NUM_WORDS)) begin : g_bad_idx_w
        $error("config_loader: IDX_W too small for NUM_WORDS");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                 state, state_nxt;
    logic                   ready_nxt, busy_nxt, done_nxt, load_word;
    logic [IDX_W-1:0]       idx_nxt;
    logic [NUM_WORDS-1:0]   en_dec;

`ifdef CFG_LOADER_CHECKSUM_EN
    logic                   chk_word, start_accept;
    logic [WORD_W-1:0]      run_xor;
`endif

    // Enable is computed from SETUP so the registered pulse lands exactly in STROBE.
    config_en_decoder #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_en_dec (
        .idx    (io_word_idx),
        .strobe (state == SETUP),
        .en     (en_dec)
    );

    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        busy_nxt  = io_busy;
        done_nxt  = 1'b0;
        idx_nxt   = io_word_idx;
        load_word = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
        chk_word  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (io_start) begin
                    state_nxt = FETCH;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    idx_nxt   = '0;
                end
            end
            FETCH: begin
                if (io_in_valid && io_in_ready) begin
                    state_nxt = SETUP;
                    load_word = 1'b1;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            SETUP:  state_nxt = STROBE;
            STROBE: state_nxt = HOLD;
            HOLD: begin
                if (io_word_idx == LAST_IDX) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
                    ready_nxt = 1'b1;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
`endif
                end else begin
                    state_nxt = FETCH;
                    ready_nxt = 1'b1;
                    idx_nxt   = io_word_idx + 1'b1;
                end
            end
`ifdef CFG_LOADER_CHECKSUM_EN
            CHK: begin
                if (io_in_valid && io_in_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    chk_word  = 1'b1;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            io_in_ready   <= 1'b0;
            io_busy       <= 1'b0;
            io_done       <= 1'b0;
            io_word_idx   <= '0;
            io_configs_en <= '0;
            io_d_out      <= '0;
        end else begin
            state         <= state_nxt;
            io_in_ready   <= ready_nxt;
            io_busy       <= busy_nxt;
            io_done       <= done_nxt;
            io_word_idx   <= idx_nxt;
            io_configs_en <= en_dec;
            if (load_word) begin
                io_d_out <= io_in_data;
            end
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    assign start_accept = (state == IDLE) && io_start;

    // Running XOR restarts with each load; no reset needed since start clears it.
    always_ff @(posedge clk) begin
        if (start_accept) begin
            run_xor <= '0;
        end else if (load_word) begin
            run_xor <= run_xor ^ io_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_cfg_err <= 1'b0;
        end else if (start_accept) begin
            io_cfg_err <= 1'b0;
        end else if (chk_word) begin
            io_cfg_err <= (io_in_data != run_xor);
        end
    end
`endif

endmodule
